vector_drain: RTL and testbench
===============================

// Module: vector_drain
// PURPOSE
//   Downstream stage of the vector-sum datapath. On start, it reads VECTOR_SIZE
//   words from the z result BRAM (synchronous read, 1-cycle latency).
//   It pushes each word, in address order, into an output FIFO and honours the
//   FIFO's full back-pressure. done is a level that rises when the last word is
//   written. It stays high until the next accepted start.
// PARAMETERS
//   DATA_WIDTH   32    width of z words and FIFO data
//   ADDR_WIDTH   10    z BRAM address width
//   VECTOR_SIZE  1024  words to drain; 1..2**ADDR_WIDTH inclusive
// PORTS
//   clock      in   1           single clock, rising edge
//   reset      in   1           asynchronous, active-high
//   start      in   1           begin drain; sampled only in S_IDLE
//   done       out  1           drain complete (level)
//   z_dout     in   DATA_WIDTH  z BRAM read data, valid 1 cycle after z_addr
//   z_addr     out  ADDR_WIDTH  z BRAM read address
//   out_din    out  DATA_WIDTH  FIFO write data
//   out_wr_en  out  1           FIFO write strobe
//   out_full   in   1           FIFO full; no write while high
//   checksum   out  DATA_WIDTH  running sum of words written (see CONFIGURATION)
// BEHAVIOUR
//   Reset: state=S_IDLE, done=0, index=0, checksum=0. out_wr_en=0, z_addr=0 and
//     out_din=0 combinationally.
//   Index counter is ADDR_WIDTH+1 bits, so VECTOR_SIZE=2**ADDR_WIDTH terminates
//     without wrap. z_addr = index[ADDR_WIDTH-1:0].
//   S_IDLE: index<=0. On start=1: done<=0, checksum<=0, go S_READ.
//     start while not in S_IDLE is ignored.
//   S_READ: if index<VECTOR_SIZE, drive z_addr=index and go S_WRITE.
//     Otherwise done<=1 and go S_IDLE.
//   S_WRITE: hold z_addr=index, so z_dout stays stable while stalled.
//     If out_full=0: out_din=z_dout, out_wr_en=1, index<=index+1, go S_READ.
//     If out_full=1: out_wr_en=0, stay in S_WRITE. Wait indefinitely; no drop,
//     no duplicate.
//   out_wr_en is never asserted while out_full=1 (combinational gate).
//   Throughput: 1 word per 2 cycles without stalls. Each full cycle adds 1 cycle.
//   Latency: with start sampled in cycle 0 and no stalls, done is first high in
//     cycle 2*VECTOR_SIZE+2.
//   out_full toggling every cycle: every word is still written exactly once.
//   Reset mid-drain: immediate abort to the reset state. Partial FIFO contents
//     are not recalled.
//   Illegal state encoding: return to S_IDLE. Outputs are X in simulation.
// CONFIGURATION
//   Macro VECTOR_DRAIN_CHECKSUM_EN.
//   Defined: each FIFO write adds out_din to checksum, modulo 2**DATA_WIDTH
//     (unsigned wrap, same bits as signed two's complement). The sum is
//     registered and updates in the cycle after the write. It is cleared on
//     accepted start and holds its value after done.
//   Undefined: checksum is tied to 0 and no accumulator logic is built.
// STRUCTURE
//   Package vector_pkg: state enum drain_state_t {S_IDLE,S_READ,S_WRITE}
//     (logic [1:0]), and shared DATA_WIDTH/ADDR_WIDTH/VECTOR_SIZE defaults
//     localparams.
//   One sub-module, vector_checksum (clock, reset, clr, en, din, sum). It is
//     instantiated only under VECTOR_DRAIN_CHECKSUM_EN. FSM and counter stay
//     in vector_drain.
// TESTING
//   Use a BRAM model with 1-cycle read latency and a FIFO model with
//   controllable full.
//   1 Basic: VECTOR_SIZE=8, z[i]=i+1, out_full=0. Expect FIFO to receive
//     1..8 in order and done=1 in cycle 18 after start. With macro: checksum=36.
//   2 Back-pressure: out_full=1 for 5 cycles during word 3, then random 50%.
//     Expect exactly 8 writes, no out_wr_en while full, same order, z_addr
//     stable during stall.
//   3 Full depth: ADDR_WIDTH=4, VECTOR_SIZE=16. Expect 16 words and
//     termination with no wrap to address 0.
//   4 Wrap/sign: z = 0xFFFFFFFF x4 and 0x00000002 x4. With macro:
//     checksum=0x00000004. Without macro: checksum=0.
//   5 Control: start pulsed mid-drain is ignored. reset at word 4 forces
//     out_wr_en=0 and done=0 at once. A new start then drains all 8 words
//     from address 0.
//   6 Re-run: second start after done drops done the next cycle and repeats
//     the identical stream.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared types and default sizes for the vector-sum drain stage.
package vector_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 10;
    localparam int DEF_VECTOR_SIZE = 1024;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } drain_state_t;

endpackage

// File: rtl/vector_checksum.sv
// Registered modulo-2**DATA_WIDTH accumulator of words written to the output FIFO.
module vector_checksum #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] sum
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/vector_drain.sv
// Drains VECTOR_SIZE words from the z result BRAM into an output FIFO.
// Optional running checksum is built only when VECTOR_DRAIN_CHECKSUM_EN is defined.
module vector_drain
    import vector_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int VECTOR_SIZE = DEF_VECTOR_SIZE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] z_dout,
    output logic [ADDR_WIDTH-1:0] z_addr,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  out_wr_en,
    input  logic                  out_full,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic [1:0]            state
);

    // FIFO handshake: a word is transferred on every rising clock edge where
    // out_wr_en=1; out_wr_en is gated by !out_full so a full FIFO is never written.

    // One extra index bit lets VECTOR_SIZE == 2**ADDR_WIDTH terminate without wrapping.
    localparam logic [ADDR_WIDTH:0] LAST_COUNT = (ADDR_WIDTH + 1)'(VECTOR_SIZE);

    drain_state_t          state_q, state_d;
    logic [ADDR_WIDTH:0]   index_q, index_d;
    logic                  done_q, done_d;
    logic                  sum_clr;

    assign state   = state_q;
    assign done    = done_q;
    assign sum_clr = (state_q == S_IDLE) && start;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            index_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        done_d    = done_q;
        z_addr    = '0;
        out_din   = '0;
        out_wr_en = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                index_d = '0;
                if (start) begin
                    done_d  = 1'b0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (index_q < LAST_COUNT) begin
                    z_addr  = index_q[ADDR_WIDTH-1:0];
                    state_d = S_WRITE;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                // Address held through a stall keeps z_dout stable for the retry.
                z_addr = index_q[ADDR_WIDTH-1:0];
                if (!out_full) begin
                    out_din   = z_dout;
                    out_wr_en = 1'b1;
                    index_d   = index_q + 1'b1;
                    state_d   = S_READ;
                end
            end
            default: begin
                state_d   = S_IDLE;
                z_addr    = 'x;
                out_din   = 'x;
                out_wr_en = 1'bx;
            end
        endcase
    end

`ifdef VECTOR_DRAIN_CHECKSUM_EN
    vector_checksum #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_checksum (
        .clock (clock),
        .reset (reset),
        .clr   (sum_clr),
        .en    (out_wr_en),
        .din   (out_din),
        .sum   (checksum)
    );
`else
    logic unused_sum_clr;
    assign unused_sum_clr = sum_clr;
    assign checksum       = '0;
`endif

endmodule

// File: tb/tb_vector_drain.sv
// Scoreboard bench for vector_drain: an 8-word drain (wide address) and a 16-word full-depth drain.
module tb_vector_drain;
    import vector_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    // instance a: ADDR_WIDTH=10, VECTOR_SIZE=8
    logic        start_a = 1'b0, done_a, out_wr_en_a, out_full_a = 1'b0;
    logic [31:0] z_dout_a = '0, out_din_a, checksum_a;
    logic [9:0]  z_addr_a;
    logic [1:0]  state_a;
    logic [31:0] mem_a [0:1023];

    // instance b: ADDR_WIDTH=4, VECTOR_SIZE=16
    logic        start_b = 1'b0, done_b, out_wr_en_b, out_full_b = 1'b0;
    logic [31:0] z_dout_b = '0, out_din_b, checksum_b;
    logic [3:0]  z_addr_b;
    logic [1:0]  state_b;
    logic [31:0] mem_b [0:15];

    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          wr_cnt_a = 0;
    int          wr_cnt_b = 0;
    logic        stall_prev_a = 1'b0;
    logic [9:0]  addr_prev_a = '0;
    logic        csum_on;

    vector_drain #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .VECTOR_SIZE(8)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .done(done_a),
        .z_dout(z_dout_a), .z_addr(z_addr_a), .out_din(out_din_a),
        .out_wr_en(out_wr_en_a), .out_full(out_full_a), .checksum(checksum_a),
        .state(state_a)
    );

    vector_drain #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .VECTOR_SIZE(16)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .done(done_b),
        .z_dout(z_dout_b), .z_addr(z_addr_b), .out_din(out_din_b),
        .out_wr_en(out_wr_en_b), .out_full(out_full_b), .checksum(checksum_b),
        .state(state_b)
    );

    // clock / BRAM models (1-cycle read latency)
    always #5 clock = ~clock;
    always @(posedge clock) z_dout_a <= mem_a[z_addr_a];
    always @(posedge clock) z_dout_b <= mem_b[z_addr_b];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // FIFO-side monitors
    always @(negedge clock) begin
        if (!reset) begin
            if (out_wr_en_a) begin
                check("no_wr_while_full_a", {31'd0, out_full_a}, 32'd0);
                if (exp_a.size() == 0) check("unexpected_write_a", out_din_a, 32'hDEAD_BEEF);
                else check("word_a", out_din_a, exp_a.pop_front());
                wr_cnt_a++;
            end
            if (stall_prev_a && state_a == S_WRITE)
                check("zaddr_stable_a", {22'd0, z_addr_a}, {22'd0, addr_prev_a});
            stall_prev_a = (state_a == S_WRITE) && out_full_a;
            addr_prev_a  = z_addr_a;
        end else begin
            stall_prev_a = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (!reset && out_wr_en_b) begin
            check("no_wr_while_full_b", {31'd0, out_full_b}, 32'd0);
            if (exp_b.size() == 0) check("unexpected_write_b", out_din_b, 32'hDEAD_BEEF);
            else check("word_b", out_din_b, exp_b.pop_front());
            wr_cnt_b++;
        end
    end

    // driver tasks
    task automatic load_a_seq();
        for (int i = 0; i < 8; i++) mem_a[i] = 32'(i + 1);
    endtask

    task automatic push_a();
        for (int i = 0; i < 8; i++) exp_a.push_back(mem_a[i]);
    endtask

    // Returns just after the edge that samples start.
    task automatic pulse_start_a();
        @(posedge clock); #1 start_a = 1'b1;
        @(posedge clock); #1 start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int max_edges, output int edges);
        edges = 0;
        while (!done_a && edges < max_edges) begin
            @(posedge clock); #1;
            edges++;
        end
        if (!done_a) check("timeout_done_a", {31'd0, done_a}, 32'd1);
    endtask

    task automatic end_of_run_a(input string tag, input logic [31:0] exp_sum);
        repeat (3) @(posedge clock);
        #1;
        check({tag, "_writes"}, 32'(wr_cnt_a), 32'd8);
        check({tag, "_queue_empty"}, 32'(exp_a.size()), 32'd0);
        check({tag, "_checksum"}, checksum_a, csum_on ? exp_sum : 32'd0);
        check({tag, "_done_held"}, {31'd0, done_a}, 32'd1);
    endtask

    initial begin
        int edges;
        int stall_left;
        logic stalled;
`ifdef VECTOR_DRAIN_CHECKSUM_EN
        csum_on = 1'b1;
`else
        csum_on = 1'b0;
`endif
        for (int i = 0; i < 1024; i++) mem_a[i] = 32'hBAD0_0000 | 32'(i);
        for (int i = 0; i < 16; i++) mem_b[i] = 32'h100 + 32'(i * 3);
        load_a_seq();

        // reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_wr_en", {31'd0, out_wr_en_a}, 32'd0);
        check("rst_z_addr", {22'd0, z_addr_a}, 32'd0);
        check("rst_out_din", out_din_a, 32'd0);
        check("rst_checksum", checksum_a, 32'd0);
        check("rst_state", {30'd0, state_a}, 32'(S_IDLE));
        @(negedge clock) reset = 1'b0;

        // 1 basic: 1..8, done in cycle 18 (17 edges after the start-sampling edge)
        wr_cnt_a = 0;
        push_a();
        pulse_start_a();
        wait_done_a(200, edges);
        check("t1_done_cycle", 32'(edges + 1), 32'd18);
        end_of_run_a("t1", 32'd36);

        // 6 re-run: done drops the cycle after start, identical stream
        wr_cnt_a = 0;
        push_a();
        pulse_start_a();
        check("t6_done_drop", {31'd0, done_a}, 32'd0);
        wait_done_a(200, edges);
        check("t6_done_cycle", 32'(edges + 1), 32'd18);
        end_of_run_a("t6", 32'd36);

        // 2 back-pressure: 5-cycle stall on word 3, then random 50%
        wr_cnt_a = 0;
        stalled = 1'b0;
        stall_left = 0;
        push_a();
        pulse_start_a();
        for (int c = 0; c < 400 && !done_a; c++) begin
            if (!stalled && wr_cnt_a == 2 && state_a == S_WRITE) begin
                stalled = 1'b1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                out_full_a = 1'b1;
                stall_left--;
            end else if (stalled) begin
                out_full_a = 1'($urandom_range(0, 1));
            end
            @(posedge clock); #1;
        end
        out_full_a = 1'b0;
        check("t2_stall_seen", {31'd0, stalled}, 32'd1);
        check("t2_done", {31'd0, done_a}, 32'd1);
        end_of_run_a("t2", 32'd36);

        // 4 wrap/sign: -1 x4 + 2 x4 = 4
        for (int i = 0; i < 8; i++) mem_a[i] = (i < 4) ? 32'hFFFF_FFFF : 32'h0000_0002;
        wr_cnt_a = 0;
        push_a();
        pulse_start_a();
        wait_done_a(200, edges);
        end_of_run_a("t4", 32'h0000_0004);

        // 5 control: start mid-drain ignored, reset at word 4, full re-drain
        load_a_seq();
        wr_cnt_a = 0;
        push_a();
        pulse_start_a();
        for (int c = 0; c < 100 && wr_cnt_a < 2; c++) @(posedge clock);
        #1 start_a = 1'b1;
        @(posedge clock); #1 start_a = 1'b0;
        for (int c = 0; c < 100 && !(wr_cnt_a == 4 && state_a == S_WRITE); c++) begin
            @(posedge clock); #1;
        end
        check("t5_reached_word4", 32'(wr_cnt_a), 32'd4);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_wr_en", {31'd0, out_wr_en_a}, 32'd0);
        check("t5_rst_done", {31'd0, done_a}, 32'd0);
        check("t5_rst_z_addr", {22'd0, z_addr_a}, 32'd0);
        exp_a.delete();
        @(negedge clock) reset = 1'b0;
        wr_cnt_a = 0;
        push_a();
        pulse_start_a();
        wait_done_a(200, edges);
        check("t5_done_cycle", 32'(edges + 1), 32'd18);
        end_of_run_a("t5", 32'd36);

        // 3 full depth: 16 words, no wrap back to address 0
        wr_cnt_b = 0;
        for (int i = 0; i < 16; i++) exp_b.push_back(mem_b[i]);
        @(posedge clock); #1 start_b = 1'b1;
        @(posedge clock); #1 start_b = 1'b0;
        edges = 0;
        while (!done_b && edges < 200) begin
            @(posedge clock); #1;
            edges++;
        end
        check("t3_done_cycle", 32'(edges + 1), 32'd34);
        repeat (6) @(posedge clock);
        #1;
        check("t3_writes", 32'(wr_cnt_b), 32'd16);
        check("t3_queue_empty", 32'(exp_b.size()), 32'd0);
        check("t3_idle", {30'd0, state_b}, 32'(S_IDLE));
        check("t3_checksum", checksum_b, csum_on ? 32'd4456 : 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
